cache_mem_responder: RTL and testbench



---
 rtl/cache_mem_responder_if.sv | 31 +++
 rtl/cache_mem_responder.sv | 162 ++++++++++++++++
 tb/tb_cache_mem_responder.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_responder_if.sv
// Cache <-> memory responder request/return bundle.
// master = cache side, slave = responder side.
interface cache_mem_responder_if;
  logic         i_LoadRequire;
  logic [2:0]   i_LoadWidth;
  logic [31:0]  i_LoadAddr;
  logic         o_LoadReady;
  logic         o_ReturnValid;
  logic [1:0]   o_ReturnLast;
  logic [31:0]  o_ReturnData;
  logic         i_WriteRequire;
  logic [2:0]   i_WriteWidth;
  logic [31:0]  i_WriteAddr;
  logic [3:0]   i_WriteByteEnable;
  logic [127:0] i_WriteData;
  logic         o_WriteReady;

  modport master (
    output i_LoadRequire, i_LoadWidth, i_LoadAddr,
    input  o_LoadReady, o_ReturnValid, o_ReturnLast, o_ReturnData,
    output i_WriteRequire, i_WriteWidth, i_WriteAddr, i_WriteByteEnable, i_WriteData,
    input  o_WriteReady
  );

  modport slave (
    input  i_LoadRequire, i_LoadWidth, i_LoadAddr,
    output o_LoadReady, o_ReturnValid, o_ReturnLast, o_ReturnData,
    input  i_WriteRequire, i_WriteWidth, i_WriteAddr, i_WriteByteEnable, i_WriteData,
    output o_WriteReady
  );
endinterface

// File: rtl/cache_mem_responder.sv
// Backing-store responder for cache refill/write-back: word/line reads, masked/line writes.
// Optional CACHE_RESP_ADDR_CHECK_EN: out-of-range accesses flagged/suppressed instead of wrapping.
module cache_mem_responder #(
  parameter int unsigned MEM_WORDS     = 4096,
  parameter int unsigned READ_LATENCY  = 2,
  parameter int unsigned WRITE_LATENCY = 1
) (
  input logic clk,
  input logic rstn,
  cache_mem_responder_if.slave bus
);
  localparam int unsigned AddrW  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned MaxLat = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);
  localparam logic [2:0] WidthLine = 3'b100;
`ifdef CACHE_RESP_ADDR_CHECK_EN
  localparam bit AddrCheck = 1'b1;
`else
  localparam bit AddrCheck = 1'b0;
`endif

  typedef enum logic [1:0] {Idle, RdWait, RdBurst, WrBusy} stateT;

  logic [31:0] mem [MEM_WORDS];

  stateT           stateQ, stateD;
  logic [CntW-1:0] cntQ, cntD;
  logic [1:0]      beatQ, beatD;
  logic [29:0]     rdAddrQ, rdAddrD;
  logic            rdLineQ, rdLineD;
  logic            readyQ, readyD;
  logic            validQ, validD;
  logic [1:0]      lastQ, lastD;
  logic [31:0]     dataQ, dataD;
  logic            emit;
  logic [29:0]     beatIdx;
  logic            beatOk;
  logic            wrAccept, rdAccept;
  logic [29:0]     wrWord;

  function automatic logic inRange(logic [29:0] idx);
    return !AddrCheck || ({2'b00, idx} < MEM_WORDS);
  endfunction

  // Write wins a same-cycle collision so a dirty victim lands before its refill read.
  assign wrAccept = readyQ & bus.i_WriteRequire;
  assign rdAccept = readyQ & bus.i_LoadRequire & ~bus.i_WriteRequire;

  assign bus.o_LoadReady   = readyQ & ~bus.i_WriteRequire;
  assign bus.o_WriteReady  = readyQ;
  assign bus.o_ReturnValid = validQ;
  assign bus.o_ReturnLast  = lastQ;
  assign bus.o_ReturnData  = dataQ;

  always_comb begin
    stateD  = stateQ;
    cntD    = cntQ;
    beatD   = beatQ;
    rdAddrD = rdAddrQ;
    rdLineD = rdLineQ;
    emit    = 1'b0;
    unique case (stateQ)
      Idle: begin
        if (wrAccept) begin
          stateD = WrBusy;
          cntD   = CntW'(WRITE_LATENCY - 1);
        end else if (rdAccept) begin
          rdAddrD = bus.i_LoadAddr[31:2];
          rdLineD = (bus.i_LoadWidth == WidthLine);
          beatD   = 2'd0;
          if (READ_LATENCY == 1) begin
            stateD = RdBurst;
            emit   = 1'b1;
          end else begin
            stateD = RdWait;
            cntD   = CntW'(READ_LATENCY - 2);
          end
        end
      end
      RdWait: begin
        if (cntQ == '0) begin
          stateD = RdBurst;
          emit   = 1'b1;
        end else begin
          cntD = cntQ - 1'b1;
        end
      end
      RdBurst: begin
        if (!rdLineQ || beatQ == 2'd3) begin
          stateD = Idle;
        end else begin
          beatD = beatQ + 2'd1;
          emit  = 1'b1;
        end
      end
      WrBusy: begin
        if (cntQ == '0) stateD = Idle;
        else            cntD   = cntQ - 1'b1;
      end
      default: stateD = Idle;
    endcase
    readyD = (stateD == Idle);
  end

  // Line bursts always start at word 0 of the line, whatever addr[3:2] says.
  always_comb begin
    beatIdx = rdLineD ? {rdAddrD[29:2], beatD} : rdAddrD;
    beatOk  = inRange(beatIdx);
    validD  = emit;
    lastD   = 2'b00;
    dataD   = '0;
    if (emit) begin
      lastD = {~beatOk, ~rdLineD | (beatD == 2'd3)};
      if (beatOk) dataD = mem[beatIdx[AddrW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stateQ  <= Idle;
      cntQ    <= '0;
      beatQ   <= '0;
      rdAddrQ <= '0;
      rdLineQ <= 1'b0;
      readyQ  <= 1'b0;
      validQ  <= 1'b0;
      lastQ   <= 2'b00;
      dataQ   <= '0;
    end else begin
      stateQ  <= stateD;
      cntQ    <= cntD;
      beatQ   <= beatD;
      rdAddrQ <= rdAddrD;
      rdLineQ <= rdLineD;
      readyQ  <= readyD;
      validQ  <= validD;
      lastQ   <= lastD;
      dataQ   <= dataD;
    end
  end

  assign wrWord = bus.i_WriteAddr[31:2];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wrAccept) begin
      if (bus.i_WriteWidth == WidthLine) begin
        for (int k = 0; k < 4; k++) begin
          if (inRange({wrWord[29:2], 2'(k)})) begin
            mem[{wrWord[AddrW-1:2], 2'(k)}] <= bus.i_WriteData[32*k +: 32];
          end
        end
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (bus.i_WriteByteEnable[b] && inRange(wrWord)) begin
            mem[wrWord[AddrW-1:0]][8*b +: 8] <= bus.i_WriteData[8*b +: 8];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder (MEM_WORDS=4096, READ_LATENCY=2, WRITE_LATENCY=1).
module tb_cache_mem_responder;
  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  int          rdLat;
  int          rdCount;
  logic [31:0] rdData [8];
  logic [1:0]  rdLast [8];
  logic        rdReadyAfter;
  logic [31:0] rdDataAfter;

  cache_mem_responder_if bus ();

  cache_mem_responder #(
    .MEM_WORDS    (4096),
    .READ_LATENCY (2),
    .WRITE_LATENCY(1)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && !bus.o_WriteReady; i++) tick();
    if (!bus.o_WriteReady) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got=%b want=1", bus.o_WriteReady);
    end
  endtask

  task automatic collect_beats();
    rdLat   = 1;
    rdCount = 0;
    while (!bus.o_ReturnValid && rdLat < 20) begin
      tick();
      rdLat++;
    end
    while (bus.o_ReturnValid && rdCount < 8) begin
      rdData[rdCount] = bus.o_ReturnData;
      rdLast[rdCount] = bus.o_ReturnLast;
      rdCount++;
      tick();
    end
    rdReadyAfter = bus.o_LoadReady;
    rdDataAfter  = bus.o_ReturnData;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [2:0] width,
                          input logic [3:0] be, input logic [127:0] data);
    wait_ready();
    bus.i_WriteRequire    = 1'b1;
    bus.i_WriteAddr       = addr;
    bus.i_WriteWidth      = width;
    bus.i_WriteByteEnable = be;
    bus.i_WriteData       = data;
    tick();
    bus.i_WriteRequire = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [2:0] width);
    wait_ready();
    bus.i_LoadRequire = 1'b1;
    bus.i_LoadAddr    = addr;
    bus.i_LoadWidth   = width;
    tick();
    bus.i_LoadRequire = 1'b0;
    collect_beats();
  endtask

  task automatic test_reset();
    #23;
    checks++;
    if ({bus.o_ReturnValid, bus.o_ReturnLast, bus.o_LoadReady, bus.o_WriteReady} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b want=00000",
               {bus.o_ReturnValid, bus.o_ReturnLast, bus.o_LoadReady, bus.o_WriteReady});
    end
    checks++;
    if (bus.o_ReturnData !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got=%h want=0", bus.o_ReturnData);
    end
    rstn = 1'b1;
    #1;
    checks++;
    if (bus.o_WriteReady !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge got=%b want=0", bus.o_WriteReady);
    end
    tick();
    checks++;
    if ({bus.o_LoadReady, bus.o_WriteReady} !== 2'b11) begin
      errors++;
      $display("FAIL ready_after_reset got=%b want=11", {bus.o_LoadReady, bus.o_WriteReady});
    end
  endtask

  task automatic test_line();
    logic [31:0] exp [4];
    exp[0] = 32'h11111111; exp[1] = 32'h22222222;
    exp[2] = 32'h33333333; exp[3] = 32'h44444444;
    do_write(32'h40, 3'b100, 4'b0000, 128'h44444444_33333333_22222222_11111111);
    checks++;
    if ({bus.o_LoadReady, bus.o_WriteReady} !== 2'b00) begin
      errors++;
      $display("FAIL write_busy got=%b want=00", {bus.o_LoadReady, bus.o_WriteReady});
    end
    tick();
    checks++;
    if (bus.o_WriteReady !== 1'b1) begin
      errors++;
      $display("FAIL write_done got=%b want=1", bus.o_WriteReady);
    end
    do_read(32'h48, 3'b100);
    checks++;
    if (rdLat !== 2) begin
      errors++;
      $display("FAIL line_latency got=%0d want=2", rdLat);
    end
    checks++;
    if (rdCount !== 4) begin
      errors++;
      $display("FAIL line_beats got=%0d want=4", rdCount);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rdData[i] !== exp[i] || rdLast[i] !== ((i == 3) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL line_beat%0d got=%h/%b want=%h/%b", i, rdData[i], rdLast[i], exp[i],
                 (i == 3) ? 2'b01 : 2'b00);
      end
    end
    checks++;
    if (rdReadyAfter !== 1'b1 || rdDataAfter !== 32'h0) begin
      errors++;
      $display("FAIL line_end got=%b/%h want=1/0", rdReadyAfter, rdDataAfter);
    end
  endtask

  task automatic test_byte_enable();
    do_write(32'h100, 3'b010, 4'b1111, 128'hAABBCCDD);
    do_write(32'h100, 3'b111, 4'b0101, 128'h11223344);
    do_read(32'h102, 3'b001);
    checks++;
    if (rdCount !== 1 || rdData[0] !== 32'hAA22CC44 || rdLast[0] !== 2'b01) begin
      errors++;
      $display("FAIL be_half got=%0d/%h/%b want=1/aa22cc44/01", rdCount, rdData[0], rdLast[0]);
    end
    do_read(32'h103, 3'b011);
    checks++;
    if (rdCount !== 1 || rdData[0] !== 32'hAA22CC44 || rdLat !== 2) begin
      errors++;
      $display("FAIL be_w011 got=%0d/%h/%0d want=1/aa22cc44/2", rdCount, rdData[0], rdLat);
    end
  endtask

  task automatic test_simultaneous();
    wait_ready();
    bus.i_WriteRequire = 1'b1;
    bus.i_WriteAddr    = 32'h200;
    bus.i_WriteWidth   = 3'b100;
    bus.i_WriteData    = 128'hA0000003_A0000002_A0000001_A0000000;
    bus.i_LoadRequire  = 1'b1;
    bus.i_LoadAddr     = 32'h200;
    bus.i_LoadWidth    = 3'b100;
    #1;
    checks++;
    if ({bus.o_LoadReady, bus.o_WriteReady} !== 2'b01) begin
      errors++;
      $display("FAIL collide_ready got=%b want=01", {bus.o_LoadReady, bus.o_WriteReady});
    end
    tick();
    bus.i_WriteRequire = 1'b0;
    checks++;
    if (bus.o_LoadReady !== 1'b0) begin
      errors++;
      $display("FAIL collide_busy got=%b want=0", bus.o_LoadReady);
    end
    tick();
    checks++;
    if (bus.o_LoadReady !== 1'b1) begin
      errors++;
      $display("FAIL collide_rd_ready got=%b want=1", bus.o_LoadReady);
    end
    tick();
    bus.i_LoadRequire = 1'b0;
    collect_beats();
    checks++;
    if (rdCount !== 4 || rdLat !== 2) begin
      errors++;
      $display("FAIL collide_rd got=%0d/%0d want=4/2", rdCount, rdLat);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rdData[i] !== (32'hA0000000 | i)) begin
        errors++;
        $display("FAIL collide_beat%0d got=%h want=%h", i, rdData[i], 32'hA0000000 | i);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  vSeen;
    logic [5:0]  rSeen;
    logic [31:0] beatData;
    vSeen    = '0;
    rSeen    = '0;
    beatData = '0;
    wait_ready();
    bus.i_LoadRequire = 1'b1;
    bus.i_LoadAddr    = 32'h100;
    bus.i_LoadWidth   = 3'b010;
    for (int k = 0; k < 6; k++) begin
      tick();
      vSeen[k] = bus.o_ReturnValid;
      rSeen[k] = bus.o_LoadReady;
      if (k == 1) beatData = bus.o_ReturnData;
    end
    bus.i_LoadRequire = 1'b0;
    checks++;
    if (vSeen !== 6'b010010) begin
      errors++;
      $display("FAIL b2b_valid got=%b want=010010", vSeen);
    end
    checks++;
    if (rSeen !== 6'b100100) begin
      errors++;
      $display("FAIL b2b_ready got=%b want=100100", rSeen);
    end
    checks++;
    if (beatData !== 32'hAA22CC44) begin
      errors++;
      $display("FAIL b2b_data got=%h want=aa22cc44", beatData);
    end
  endtask

  task automatic test_reset_midburst();
    wait_ready();
    bus.i_LoadRequire = 1'b1;
    bus.i_LoadAddr    = 32'h40;
    bus.i_LoadWidth   = 3'b100;
    tick();
    bus.i_LoadRequire = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.o_ReturnValid !== 1'b1 || bus.o_ReturnData !== 32'h22222222) begin
      errors++;
      $display("FAIL mid_beat1 got=%b/%h want=1/22222222", bus.o_ReturnValid, bus.o_ReturnData);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({bus.o_ReturnValid, bus.o_LoadReady, bus.o_WriteReady} !== 3'b000 ||
        bus.o_ReturnData !== 32'h0 || bus.o_ReturnLast !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset got=%b/%h/%b want=000/0/00",
               {bus.o_ReturnValid, bus.o_LoadReady, bus.o_WriteReady}, bus.o_ReturnData,
               bus.o_ReturnLast);
    end
    #3 rstn = 1'b1;
    tick();
    checks++;
    if ({bus.o_LoadReady, bus.o_WriteReady, bus.o_ReturnValid} !== 3'b110) begin
      errors++;
      $display("FAIL mid_release got=%b want=110",
               {bus.o_LoadReady, bus.o_WriteReady, bus.o_ReturnValid});
    end
    do_read(32'h40, 3'b100);
    checks++;
    if (rdCount !== 4 || rdData[0] !== 32'h11111111 || rdData[3] !== 32'h44444444) begin
      errors++;
      $display("FAIL mid_preserved got=%0d/%h/%h want=4/11111111/44444444", rdCount, rdData[0],
               rdData[3]);
    end
  endtask

  task automatic test_wrap();
`ifdef CACHE_RESP_ADDR_CHECK_EN
    do_write(32'h0, 3'b010, 4'b1111, 128'h12345678);
    do_write(32'h4000, 3'b010, 4'b1111, 128'hC0FFEE01);
    do_read(32'h4000, 3'b010);
    checks++;
    if (rdCount !== 1 || rdData[0] !== 32'h0 || rdLast[0] !== 2'b11) begin
      errors++;
      $display("FAIL oob_read got=%0d/%h/%b want=1/0/11", rdCount, rdData[0], rdLast[0]);
    end
    do_read(32'h0, 3'b010);
    checks++;
    if (rdData[0] !== 32'h12345678 || rdLast[0] !== 2'b01) begin
      errors++;
      $display("FAIL oob_word0 got=%h/%b want=12345678/01", rdData[0], rdLast[0]);
    end
`else
    do_write(32'h4000, 3'b010, 4'b1111, 128'hC0FFEE01);
    do_read(32'h0, 3'b010);
    checks++;
    if (rdCount !== 1 || rdData[0] !== 32'hC0FFEE01 || rdLast[0] !== 2'b01) begin
      errors++;
      $display("FAIL wrap_read got=%0d/%h/%b want=1/c0ffee01/01", rdCount, rdData[0], rdLast[0]);
    end
`endif
  endtask

  initial begin
    checks                = 0;
    errors                = 0;
    rstn                  = 1'b0;
    bus.i_LoadRequire     = 1'b0;
    bus.i_LoadWidth       = 3'b000;
    bus.i_LoadAddr        = '0;
    bus.i_WriteRequire    = 1'b0;
    bus.i_WriteWidth      = 3'b000;
    bus.i_WriteAddr       = '0;
    bus.i_WriteByteEnable = '0;
    bus.i_WriteData       = '0;
    test_reset();
    test_line();
    test_byte_enable();
    test_simultaneous();
    test_back_to_back();
    test_reset_midburst();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
